dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder sitting on the far side of the main control unit's `memRead`/`memWrite` outputs in the RISC-V datapath. It accepts 64-bit word-aligned load (`ld`) and store (`sd`) requests, models a configurable-latency data RAM, and returns read data together with a `stall` that freezes the PC and pipeline until the access completes. Illegal requests are reported on `err` and never touch memory.

## Interface

Parameters:
- `ADDR_W`, 8: log2 of the number of 64-bit words stored; capacity 2^ADDR_W words.
- `LAT`, 2: wait cycles per access. Legal range 1..15.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `mR`  in  1: memRead from the control unit.
- `mW`  in  1: memWrite from the control unit.
- `addr`  in  64: byte address (ALU result).
- `wData`  in  64: store data (rs2).
- `rData`  out  64: load data. Valid in the `done` cycle; held until the next load completes.
- `stall`  out  1: high while a request is being serviced; the processor holds all state.
- `done`  out  1: one-cycle pulse marking access completion.
- `err`  out  1: one-cycle pulse on an illegal request.

## Operation

- States: IDLE, WAIT, DONE.
- Valid request in IDLE: exactly one of `mR`/`mW` is high, and `addr[2:0]==0`.
- Word index is `addr[ADDR_W+2:3]`. Higher address bits are ignored, so addresses wrap modulo capacity.
- IDLE with a valid request:
  - `stall`=1 combinationally in that cycle.
  - Latch op, word index and `wData`; load counter with LAT-1; go to WAIT.
- IDLE with an illegal request (`mR&mW`, or misaligned address):
  - `err`=1 combinationally in that cycle.
  - No stall, no memory access; stay in IDLE.
- WAIT:
  - `stall`=1.
  - Counter nonzero: decrement.
  - Counter zero: commit the access on this edge and go to DONE. A store writes the latched `wData`; a load registers the memory word into `rData`.
- DONE:
  - `stall`=0, `done`=1.
  - The processor completes the instruction. The request still present on the inputs is treated as the one just served and is not restarted.
  - Always go to IDLE next cycle.
- Inputs are sampled only in IDLE. Changes during WAIT or DONE are ignored, because the access uses latched values.
- Memory contents are not reset and are unknown until written. Reads of unwritten words are don't-care for verification.

## Timing

- Reset values: state IDLE, counter 0, `rData`=0, `stall`=0, `done`=0, `err`=0.
- While `rst_n`=0, the combinational outputs `stall` and `err` are forced to 0.
- Latency:
  - Request seen in IDLE at cycle T.
  - WAIT occupies T+1..T+LAT.
  - DONE at T+LAT+1.
  - `stall` is high for LAT+1 consecutive cycles (T..T+LAT).
- The store commits at the end of cycle T+LAT. `rData` is valid from cycle T+LAT+1.
- Back-to-back accesses: a request present in the cycle after DONE (IDLE) starts immediately. Minimum issue interval is LAT+2 cycles.
- Non-memory instructions (`mR`=`mW`=0) in IDLE: no stall, no pulses, zero added cycles.
- Reset mid-operation: on the edge where `rst_n`=0 is sampled, state returns to IDLE.
  - A store still in WAIT is dropped and memory is unchanged.
  - A store already committed remains.
  - `rData` is cleared to 0.
- `err` and `done` are never both high in the same cycle.

## Test plan

- Store then load, LAT=2:
  - Stimulus: `mW`=1, `addr`=0x10, `wData`=0xDEADBEEFCAFEF00D at T.
  - Required: `stall` high T..T+2; `done` at T+3.
  - Stimulus: then `mR`=1, `addr`=0x10.
  - Required: `rData`=0xDEADBEEFCAFEF00D in the `done` cycle, 3 stall cycles.
- R-type opcode, `mR`=`mW`=0, for 5 cycles: `stall`, `done` and `err` stay 0; `rData` unchanged.
- Misaligned load, `mR`=1, `addr`=0x13: `err`=1 for one cycle, `stall`=0, no state change. A following aligned load proceeds normally.
- `mR`=`mW`=1, `addr`=0x8: `err` pulses. A subsequent load of 0x8 returns the prior contents, proving no write occurred.
- Address wrap, ADDR_W=8:
  - Store 0x1111 at 0x800, which maps to word 0.
  - Load 0x0 returns 0x1111.
- Reset mid-store:
  - Store 0x2222 to 0x20 (prior value 0x5555).
  - Assert `rst_n`=0 at T+1.
  - Required: `stall`=0 during reset; `rData`=0; a later load of 0x20 returns 0x5555.
- Hold-over check: keep `mR`=1, `addr`=0x10 asserted through DONE and beyond. Exactly one `done` per LAT+2 cycles, with no extra access started in the DONE cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: services 64-bit word-aligned loads and stores with a
// fixed wait latency, stalling the pipeline until the access completes.
module dmem_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mR,
  input  logic        mW,
  input  logic [63:0] addr,
  input  logic [63:0] wData,
  output logic [63:0] rData,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int unsigned Words   = 2 ** ADDR_W;
  localparam logic [3:0]  CntInit = 4'(LAT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [63:0]         wdata_q;
  logic [63:0]         rdata_q;
  logic [63:0]         mem_q [Words];

  logic [ADDR_W-1:0]   idx;
  logic                req_ok;
  logic                accept;
  logic                commit;
  logic                unused_addr;

  // Bits above the word index are ignored so addresses wrap modulo capacity.
  assign idx         = addr[ADDR_W+2:3];
  assign unused_addr = ^addr[63:ADDR_W+3];
  assign req_ok      = (mR ^ mW) && (addr[2:0] == 3'b000);
  assign rData       = rdata_q;

  // Next-state, counter and handshake outputs; reset masks every pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (mR || mW) begin
          if (req_ok) begin
            stall   = 1'b1;
            accept  = 1'b1;
            cnt_d   = CntInit;
            state_d = StWait;
          end else begin
            err = 1'b1;
          end
        end
      end
      StWait: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        // The request still on the inputs is the one just served.
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (!rst_n) begin
      stall  = 1'b0;
      err    = 1'b0;
      done   = 1'b0;
      accept = 1'b0;
      commit = 1'b0;
    end
  end

  // Control state and load data register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit && !we_q) begin
        rdata_q <= mem_q[idx_q];
      end
    end
  end

  // Request latch; only meaningful after an accept, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= mW;
      idx_q   <= idx;
      wdata_q <= wData;
    end
  end

  // Data RAM; contents are not reset.
  always_ff @(posedge clk) begin
    if (commit && we_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes expected responses,
// a negedge monitor pops and compares them on every done/err pulse.
module tb_dmem_responder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LAT    = 2;

  logic        clk;
  logic        rst_n;
  logic        mR;
  logic        mW;
  logic [63:0] addr;
  logic [63:0] wData;
  logic [63:0] rData;
  logic        stall;
  logic        done;
  logic        err;

  typedef struct packed {
    logic        is_err;
    logic        chk;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  dmem_responder #(
    .ADDR_W(ADDR_W),
    .LAT   (LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mR   (mR),
    .mW   (mW),
    .addr (addr),
    .wData(wData),
    .rData(rData),
    .stall(stall),
    .done (done),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completion or error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (done === 1'b1 || err === 1'b1)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got done=%0b err=%0b expected no pulse", done, err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_kind", 64'({done, err}), e.is_err ? 64'd1 : 64'd2);
        if (!e.is_err && e.chk) check("sb_rData", rData, e.data);
      end
    end
  end

  // Issue one legal access (caller sits just after a posedge) and time it.
  task automatic access(input logic r, input logic w, input logic [63:0] a,
                        input logic [63:0] d, input logic [63:0] expData, input string name);
    int  stalls;
    bit  got;
    exp_t e;
    e.is_err = 1'b0;
    e.chk    = r;
    e.data   = expData;
    sb.push_back(e);
    mR = r; mW = w; addr = a; wData = d;
    stalls = 0;
    got    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (stall) stalls++;
    end
    check({name, "_done_seen"}, 64'(got), 64'd1);
    check({name, "_stall_cycles"}, 64'(stalls), 64'(LAT + 1));
    @(posedge clk);
    #1;
    mR = 1'b0; mW = 1'b0;
  endtask

  // Issue one illegal request for a single cycle.
  task automatic badReq(input logic r, input logic w, input logic [63:0] a, input string name);
    exp_t e;
    e.is_err = 1'b1;
    e.chk    = 1'b0;
    e.data   = 64'd0;
    sb.push_back(e);
    mR = r; mW = w; addr = a;
    @(negedge clk);
    check({name, "_err"}, 64'(err), 64'd1);
    check({name, "_stall"}, 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    mR = 1'b0; mW = 1'b0;
    @(negedge clk);
    check({name, "_err_cleared"}, 64'(err), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] doneMask;
    rst_n = 1'b0; mR = 1'b0; mW = 1'b0; addr = 64'd0; wData = 64'd0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rData", rData, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Store then load.
    access(1'b0, 1'b1, 64'h10, 64'hDEADBEEFCAFEF00D, 64'd0, "st10");
    access(1'b1, 1'b0, 64'h10, 64'd0, 64'hDEADBEEFCAFEF00D, "ld10");

    // Non-memory instructions: nothing moves.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rtype_stall", 64'(stall), 64'd0);
      check("rtype_done", 64'(done), 64'd0);
      check("rtype_err", 64'(err), 64'd0);
      check("rtype_rData", rData, 64'hDEADBEEFCAFEF00D);
    end
    @(posedge clk);
    #1;

    // Misaligned load, then a normal one.
    badReq(1'b1, 1'b0, 64'h13, "misalign");
    access(1'b1, 1'b0, 64'h10, 64'd0, 64'hDEADBEEFCAFEF00D, "ld10b");

    // Read and write together must not touch memory.
    access(1'b0, 1'b1, 64'h8, 64'hAAAA, 64'd0, "st08");
    badReq(1'b1, 1'b1, 64'h8, "rw_both");
    access(1'b1, 1'b0, 64'h8, 64'd0, 64'hAAAA, "ld08");

    // Address wrap: 0x800 is word 0 with 256 words.
    access(1'b0, 1'b1, 64'h800, 64'h1111, 64'd0, "st800");
    access(1'b1, 1'b0, 64'h0, 64'd0, 64'h1111, "ld00");

    // Reset during a store in WAIT drops it.
    access(1'b0, 1'b1, 64'h20, 64'h5555, 64'd0, "st20");
    mW = 1'b1; addr = 64'h20; wData = 64'h2222;
    @(negedge clk);
    check("rstmid_stall_T", 64'(stall), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0; mW = 1'b0;
    @(negedge clk);
    check("rstmid_stall", 64'(stall), 64'd0);
    check("rstmid_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_rData", rData, 64'd0);
    check("rstmid_stall_after", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 64'h20, 64'd0, 64'h5555, "ld20");

    // Request held through DONE: one completion every LAT+2 cycles.
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.is_err = 1'b0;
      e.chk    = 1'b1;
      e.data   = 64'hDEADBEEFCAFEF00D;
      sb.push_back(e);
    end
    mR = 1'b1; addr = 64'h10;
    doneMask = 12'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      doneMask[i] = done;
    end
    check("holdover_done_pattern", 64'(doneMask), 64'h888);
    @(posedge clk);
    #1;
    mR = 1'b0;

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
